pattern_sequencer: RTL

- Parametrised successor to the pushbutton sequence selector.
- Selects one of NUM_SEQ stored patterns with up/down pushbuttons.
- Steps through that pattern's entries on each slow_clk tick and drives the pattern ROM address.
- Sits between the board pushbuttons / slow clock divider and the pattern ROM. Everything runs in the clk_50 domain.

---
 rtl/seq_pkg.sv | 20 ++
 rtl/pattern_sequencer_if.sv | 35 +++
 rtl/sync_edge_detect.sv | 27 ++
 rtl/pattern_sequencer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared defaults, width helper and step-mode enum
// for the pattern sequencer slice.
package seq_pkg;

  localparam int NUM_SEQ_DEF     = 8;
  localparam int STEPS_DEF       = 16;
  localparam int WRAP_SEL_DEF    = 1;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int LOCKOUT_CYC_DEF = 16;

  function automatic int width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    MODE_LOOP    = 1'b0,
    MODE_ONESHOT = 1'b1
  } step_mode_e;

endpackage

// File: rtl/pattern_sequencer_if.sv
// Board-side bundle: raw buttons, slow clock, mode
// controls in; ROM address and status out.
interface pattern_sequencer_if
  import seq_pkg::*;
#(
  parameter int SEQ_W  = width(NUM_SEQ_DEF),
  parameter int STEP_W = width(STEPS_DEF)
);

  logic                    pb_seq_up;
  logic                    pb_seq_dn;
  logic                    slow_clk;
  logic                    run_en;
  logic                    one_shot;
  logic [SEQ_W+STEP_W-1:0] rom_addr;
  logic [SEQ_W-1:0]        seq_num;
  logic [STEP_W-1:0]       step_num;
  logic                    seq_done;
  logic                    busy;

  modport master (
    output pb_seq_up, pb_seq_dn, slow_clk,
    output run_en, one_shot,
    input  rom_addr, seq_num, step_num,
    input  seq_done, busy
  );

  modport slave (
    input  pb_seq_up, pb_seq_dn, slow_clk,
    input  run_en, one_shot,
    output rom_addr, seq_num, step_num,
    output seq_done, busy
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser followed by a rising-edge
// detector producing a one-cycle pulse.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_50,
  input  logic reset,
  input  logic async_in,
  output logic rise_p
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise_p = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/pattern_sequencer.sv
// Pushbutton sequence selector and step counter that
// drives the pattern ROM address.
module pattern_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_SEQ       = NUM_SEQ_DEF,
  parameter int STEPS_PER_SEQ = STEPS_DEF,
  parameter int SEQ_W         = width(NUM_SEQ),
  parameter int STEP_W        = width(STEPS_PER_SEQ),
  parameter int WRAP_SEL      = WRAP_SEL_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int LOCKOUT_CYC   = LOCKOUT_CYC_DEF
) (
  input logic           clk_50,
  input logic           reset,
  pattern_sequencer_if.slave bus
);

  localparam int LOCK_W = width(LOCKOUT_CYC);
  localparam logic [SEQ_W-1:0]  SEQ_MAX =
    SEQ_W'(NUM_SEQ - 1);
  localparam logic [STEP_W-1:0] STEP_MAX =
    STEP_W'(STEPS_PER_SEQ - 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD =
    LOCK_W'(LOCKOUT_CYC - 1);

  logic w_up_p;
  logic w_dn_p;
  logic w_tick_p;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_up (
    .clk_50   (clk_50),
    .reset    (reset),
    .async_in (bus.pb_seq_up),
    .rise_p   (w_up_p)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_dn (
    .clk_50   (clk_50),
    .reset    (reset),
    .async_in (bus.pb_seq_dn),
    .rise_p   (w_dn_p)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_tick (
    .clk_50   (clk_50),
    .reset    (reset),
    .async_in (bus.slow_clk),
    .rise_p   (w_tick_p)
  );

  logic [SEQ_W-1:0]  r_seq,  w_seq_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic [LOCK_W-1:0] r_lock, w_lock_nxt;
  logic              r_done, w_done_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_fin,  w_fin_nxt;
  logic              r_skip, w_skip_nxt;

  step_mode_e        w_mode;
  logic              w_accept;
  logic              w_tick_ok;
  logic [STEP_W-1:0] w_step_inc;

  assign w_mode     = step_mode_e'(bus.one_shot);
  assign w_accept   = (w_up_p ^ w_dn_p)
                    && (r_lock == '0);
  assign w_tick_ok  = w_tick_p && bus.run_en && !r_fin;
  assign w_step_inc = r_step + STEP_W'(1);

  always_comb begin
    w_seq_nxt  = r_seq;
    w_step_nxt = r_step;
    w_done_nxt = 1'b0;
    w_fin_nxt  = r_fin;
    w_skip_nxt = r_skip;
    w_lock_nxt = r_lock;
    if (r_lock != '0)
      w_lock_nxt = r_lock - LOCK_W'(1);

    // Leaving one-shot while parked at the last step:
    // the following wrap must not pulse seq_done again.
    if (r_fin && w_mode == MODE_LOOP) begin
      w_fin_nxt  = 1'b0;
      w_skip_nxt = 1'b1;
    end

    if (w_accept) begin
      w_lock_nxt = LOCK_LOAD;
      w_step_nxt = '0;
      w_fin_nxt  = 1'b0;
      w_skip_nxt = 1'b0;
      if (w_up_p) begin
        if (r_seq == SEQ_MAX)
          w_seq_nxt = (WRAP_SEL != 0) ? '0 : r_seq;
        else
          w_seq_nxt = r_seq + SEQ_W'(1);
      end else begin
        if (r_seq == '0)
          w_seq_nxt = (WRAP_SEL != 0) ? SEQ_MAX : r_seq;
        else
          w_seq_nxt = r_seq - SEQ_W'(1);
      end
    end else if (w_tick_ok) begin
      if (r_step != STEP_MAX) begin
        w_step_nxt = w_step_inc;
        if (w_mode == MODE_ONESHOT
            && w_step_inc == STEP_MAX) begin
          w_fin_nxt  = 1'b1;
          w_done_nxt = 1'b1;
        end
      end else if (w_mode == MODE_LOOP) begin
        w_step_nxt = '0;
        w_done_nxt = ~r_skip;
        w_skip_nxt = 1'b0;
      end else begin
        w_fin_nxt  = 1'b1;
        w_done_nxt = ~r_skip;
        w_skip_nxt = 1'b0;
      end
    end

    w_busy_nxt = bus.run_en & ~w_fin_nxt;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_seq  <= '0;
      r_step <= '0;
      r_lock <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
      r_fin  <= 1'b0;
      r_skip <= 1'b0;
    end else begin
      r_seq  <= w_seq_nxt;
      r_step <= w_step_nxt;
      r_lock <= w_lock_nxt;
      r_done <= w_done_nxt;
      r_busy <= w_busy_nxt;
      r_fin  <= w_fin_nxt;
      r_skip <= w_skip_nxt;
    end
  end

  assign bus.seq_num  = r_seq;
  assign bus.step_num = r_step;
  assign bus.rom_addr = {r_seq, r_step};
  assign bus.seq_done = r_done;
  assign bus.busy     = r_busy;

endmodule
